// File: rtl/dma_hold_arbiter.sv
// Hands the single data-memory port to a DMA master over the HOLD/HOLD_ACK handshake.
// Latency: HOLD sampled -> HOLD_ACK in >=2 cycles; HOLD drop -> HOLD_ACK low in 1, cpu_stall low in 2.
// Backpressure: stalls the CPU and waits for its in-flight access to drain; optional HOLD_TIMEOUT_EN forces release.
module dma_hold_arbiter #(
    parameter int ADDR_W   = 20,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              HOLD,
    output logic              HOLD_ACK,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wd,
    output logic [DATA_W-1:0] dma_rd,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wd,
    input  logic              cpu_mem_busy,
    output logic [DATA_W-1:0] cpu_rd,
    output logic              cpu_stall,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd,
    output logic [15:0]       grant_cnt,
    output logic              timeout_err,
    input  logic              err_clr
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DRAIN   = 3'd1,
        GRANT   = 3'd2,
        RELEASE = 3'd3
`ifdef HOLD_TIMEOUT_EN
        ,
        BLOCK   = 3'd4
`endif
    } state_t;

    state_t      state_q, state_d;
    logic        hold_ack_q, hold_ack_d;
    logic        cpu_stall_q, cpu_stall_d;
    logic [15:0] grant_cnt_q, grant_cnt_d;

`ifdef HOLD_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_HOLD) + 1;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             timeout_err_q, timeout_err_d;
`else
    // err_clr and MAX_HOLD have no effect when the timeout is compiled out.
    logic unused_ok;
    assign unused_ok = err_clr ^ (MAX_HOLD > 0);
`endif

    // Next-state and registered-output decode; outputs are taken from the next state so they
    // change on the same edge as the state itself.
    always_comb begin
        state_d     = state_q;
        grant_cnt_d = grant_cnt_q;
`ifdef HOLD_TIMEOUT_EN
        hold_cnt_d    = '0;
        timeout_err_d = timeout_err_q;
        if (err_clr) begin
            timeout_err_d = 1'b0;
        end
`endif
        case (state_q)
            IDLE: begin
                if (HOLD) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!HOLD) begin
                    state_d = IDLE;
                end else if (!cpu_mem_busy) begin
                    state_d = GRANT;
                end
            end
            GRANT: begin
`ifdef HOLD_TIMEOUT_EN
                hold_cnt_d = hold_cnt_q + 1'b1;
`endif
                if (!HOLD) begin
                    state_d     = RELEASE;
                    grant_cnt_d = grant_cnt_q + 16'd1;
`ifdef HOLD_TIMEOUT_EN
                end else if (hold_cnt_q == CNT_W'(MAX_HOLD - 1)) begin
                    // Set takes priority over a simultaneous err_clr.
                    state_d       = BLOCK;
                    grant_cnt_d   = grant_cnt_q + 16'd1;
                    timeout_err_d = 1'b1;
`endif
                end
            end
            RELEASE: begin
                // Always passes through IDLE so the CPU gets an unstalled cycle between grants.
                state_d = IDLE;
            end
`ifdef HOLD_TIMEOUT_EN
            BLOCK: begin
                if (!HOLD) begin
                    state_d = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

        hold_ack_d  = (state_d == GRANT);
        cpu_stall_d = (state_d == DRAIN) || (state_d == GRANT) || (state_d == RELEASE);
    end

    // State, handshake outputs and statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hold_ack_q  <= 1'b0;
            cpu_stall_q <= 1'b0;
            grant_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            hold_ack_q  <= hold_ack_d;
            cpu_stall_q <= cpu_stall_d;
            grant_cnt_q <= grant_cnt_d;
        end
    end

`ifdef HOLD_TIMEOUT_EN
    // Grant-length counter and sticky forced-release flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            hold_cnt_q    <= hold_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end
    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    // Memory-port mux: DMA owns the port only in GRANT; writes are suppressed in RELEASE/BLOCK.
    always_comb begin
        mem_we   = cpu_we;
        mem_addr = cpu_addr;
        mem_wd   = cpu_wd;
        case (state_q)
            GRANT: begin
                mem_we   = dma_we;
                mem_addr = dma_addr;
                mem_wd   = dma_wd;
            end
            RELEASE: begin
                mem_we = 1'b0;
            end
`ifdef HOLD_TIMEOUT_EN
            BLOCK: begin
                mem_we = 1'b0;
            end
`endif
            default: begin
                mem_we = cpu_we;
            end
        endcase
    end

    assign HOLD_ACK  = hold_ack_q;
    assign cpu_stall = cpu_stall_q;
    assign grant_cnt = grant_cnt_q;
    assign cpu_rd    = mem_rd;
    assign dma_rd    = mem_rd;

endmodule

// File: tb/tb_dma_hold_arbiter.sv
// Directed bench for dma_hold_arbiter: vector table plus hand sequences for timeout and async reset.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: cpu_mem_busy stimulus exercises the DRAIN wait.
module tb_dma_hold_arbiter;

    localparam int AW = 20;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          HOLD, HOLD_ACK;
    logic          dma_we;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wd, dma_rd;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wd, cpu_rd;
    logic          cpu_mem_busy, cpu_stall;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wd, mem_rd;
    logic [15:0]   grant_cnt;
    logic          timeout_err, err_clr;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dma_hold_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(8)) dut (
        .clk(clk), .rst_n(rst_n), .HOLD(HOLD), .HOLD_ACK(HOLD_ACK),
        .dma_we(dma_we), .dma_addr(dma_addr), .dma_wd(dma_wd), .dma_rd(dma_rd),
        .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
        .cpu_mem_busy(cpu_mem_busy), .cpu_rd(cpu_rd), .cpu_stall(cpu_stall),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd),
        .grant_cnt(grant_cnt), .timeout_err(timeout_err), .err_clr(err_clr)
    );

    typedef struct {
        logic          hold, busy, dwe;
        logic [AW-1:0] daddr;
        logic [DW-1:0] dwd;
        logic          cwe;
        logic [AW-1:0] caddr;
        logic [DW-1:0] cwd;
        logic          eack, estall, ewe;
        logic [AW-1:0] eaddr;
        logic [DW-1:0] ewd;
        logic [15:0]   egc;
    } vec_t;

    localparam logic [AW-1:0] CA = 20'h00200;
    localparam logic [DW-1:0] CW = 32'h11111111;
    localparam logic [AW-1:0] DA = 20'h00100;
    localparam logic [AW-1:0] WA = 20'h00040;
    localparam logic [DW-1:0] WW = 32'hCAFE0001;
    localparam logic [AW-1:0] XA = 20'h00010;
    localparam logic [DW-1:0] XW = 32'hDEADBEEF;

    vec_t tbl[22];

    function automatic vec_t mk(input logic h, b, dwe_, input logic [AW-1:0] da, input logic [DW-1:0] dw,
                                input logic cwe_, input logic [AW-1:0] ca, input logic [DW-1:0] cw,
                                input logic ack, stl, we, input logic [AW-1:0] ea, input logic [DW-1:0] ew,
                                input logic [15:0] gc);
        vec_t v;
        v.hold = h; v.busy = b; v.dwe = dwe_; v.daddr = da; v.dwd = dw;
        v.cwe = cwe_; v.caddr = ca; v.cwd = cw;
        v.eack = ack; v.estall = stl; v.ewe = we; v.eaddr = ea; v.ewd = ew; v.egc = gc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_hs(input string tag, input logic ack, input logic stl, input logic [15:0] gc,
                          input logic terr);
        chk({tag, ".ack"}, 32'(HOLD_ACK), 32'(ack));
        chk({tag, ".stall"}, 32'(cpu_stall), 32'(stl));
        chk({tag, ".gcnt"}, 32'(grant_cnt), 32'(gc));
        chk({tag, ".terr"}, 32'(timeout_err), 32'(terr));
    endtask

    initial begin
        // IDLE -> DRAIN -> GRANT, DMA write, release
        tbl[0]  = mk(1,0,0,DA,0,  0,CA,CW, 0,1,0,CA,CW, 0);
        tbl[1]  = mk(1,0,0,DA,0,  0,CA,CW, 1,1,0,DA,0,  0);
        tbl[2]  = mk(1,0,1,XA,XW, 0,CA,CW, 1,1,1,XA,XW, 0);
        tbl[3]  = mk(0,0,1,XA,XW, 0,CA,CW, 0,1,0,CA,CW, 1);
        tbl[4]  = mk(0,0,0,DA,0,  1,WA,WW, 0,0,1,WA,WW, 1);
        // busy CPU: write reaches memory during DRAIN
        tbl[5]  = mk(1,1,0,DA,0,  1,WA,WW, 0,1,1,WA,WW, 1);
        tbl[6]  = mk(1,1,0,DA,0,  1,WA,WW, 0,1,1,WA,WW, 1);
        tbl[7]  = mk(1,1,0,DA,0,  1,WA,WW, 0,1,1,WA,WW, 1);
        tbl[8]  = mk(1,0,0,DA,0,  0,CA,CW, 1,1,0,DA,0,  1);
        tbl[9]  = mk(0,0,0,DA,0,  0,CA,CW, 0,1,0,CA,CW, 2);
        tbl[10] = mk(0,0,0,DA,0,  0,CA,CW, 0,0,0,CA,CW, 2);
        // abort from DRAIN
        tbl[11] = mk(1,1,0,DA,0,  0,CA,CW, 0,1,0,CA,CW, 2);
        tbl[12] = mk(0,1,0,DA,0,  0,CA,CW, 0,0,0,CA,CW, 2);
        tbl[13] = mk(0,0,0,DA,0,  0,CA,CW, 0,0,0,CA,CW, 2);
        // back-to-back grants with HOLD re-asserted in RELEASE
        tbl[14] = mk(1,0,0,DA,0,  0,CA,CW, 0,1,0,CA,CW, 2);
        tbl[15] = mk(1,0,0,DA,0,  0,CA,CW, 1,1,0,DA,0,  2);
        tbl[16] = mk(0,0,0,DA,0,  0,CA,CW, 0,1,0,CA,CW, 3);
        tbl[17] = mk(1,0,0,DA,0,  0,CA,CW, 0,0,0,CA,CW, 3);
        tbl[18] = mk(1,0,0,DA,0,  0,CA,CW, 0,1,0,CA,CW, 3);
        tbl[19] = mk(1,0,0,DA,0,  0,CA,CW, 1,1,0,DA,0,  3);
        tbl[20] = mk(0,0,0,DA,0,  0,CA,CW, 0,1,0,CA,CW, 4);
        tbl[21] = mk(0,0,0,DA,0,  0,CA,CW, 0,0,0,CA,CW, 4);

        rst_n = 1'b0; HOLD = 1'b0; dma_we = 1'b0; dma_addr = DA; dma_wd = '0;
        cpu_we = 1'b0; cpu_addr = CA; cpu_wd = CW; cpu_mem_busy = 1'b0;
        mem_rd = 32'h5A5A0000; err_clr = 1'b0;
        #12;
        chk_hs("reset", 1'b0, 1'b0, 16'd0, 1'b0);
        chk("reset.mem_addr", 32'(mem_addr), 32'(CA));
        chk("reset.cpu_rd", cpu_rd, 32'h5A5A0000);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 22; i++) begin
            HOLD = tbl[i].hold; cpu_mem_busy = tbl[i].busy;
            dma_we = tbl[i].dwe; dma_addr = tbl[i].daddr; dma_wd = tbl[i].dwd;
            cpu_we = tbl[i].cwe; cpu_addr = tbl[i].caddr; cpu_wd = tbl[i].cwd;
            mem_rd = 32'h5A5A0000 + 32'(i);
            step();
            chk_hs($sformatf("v%0d", i), tbl[i].eack, tbl[i].estall, tbl[i].egc, 1'b0);
            chk($sformatf("v%0d.mem_we", i), 32'(mem_we), 32'(tbl[i].ewe));
            chk($sformatf("v%0d.mem_addr", i), 32'(mem_addr), 32'(tbl[i].eaddr));
            chk($sformatf("v%0d.mem_wd", i), mem_wd, tbl[i].ewd);
            chk($sformatf("v%0d.dma_rd", i), dma_rd, 32'h5A5A0000 + 32'(i));
            chk($sformatf("v%0d.cpu_rd", i), cpu_rd, 32'h5A5A0000 + 32'(i));
        end

`ifdef HOLD_TIMEOUT_EN
        // HOLD stuck high: 8 GRANT cycles then forced release into BLOCK.
        HOLD = 1'b1;
        step();
        chk_hs("to.drain", 1'b0, 1'b1, 16'd4, 1'b0);
        for (int k = 0; k < 8; k++) begin
            step();
            chk_hs($sformatf("to.grant%0d", k), 1'b1, 1'b1, 16'd4, 1'b0);
        end
        step();
        chk_hs("to.block", 1'b0, 1'b0, 16'd5, 1'b1);
        chk("to.block.mem_addr", 32'(mem_addr), 32'(CA));
        step();
        chk_hs("to.block_hold", 1'b0, 1'b0, 16'd5, 1'b1);
        err_clr = 1'b1;
        step();
        chk_hs("to.clr", 1'b0, 1'b0, 16'd5, 1'b0);
        err_clr = 1'b0;
        HOLD = 1'b0;
        step();
        chk_hs("to.idle", 1'b0, 1'b0, 16'd5, 1'b0);
        HOLD = 1'b1;
        step();
        chk_hs("to.regrant", 1'b0, 1'b1, 16'd5, 1'b0);
        HOLD = 1'b0;
        step();
        chk_hs("to.abort", 1'b0, 1'b0, 16'd5, 1'b0);
`endif

        // Asynchronous reset while in GRANT.
        HOLD = 1'b1; cpu_we = 1'b1; cpu_addr = WA; dma_addr = DA;
        step();
        step();
        chk("rg.ack_before", 32'(HOLD_ACK), 32'd1);
        chk("rg.mem_addr_before", 32'(mem_addr), 32'(DA));
        #2;
        rst_n = 1'b0;
        #1;
        chk_hs("rg.reset", 1'b0, 1'b0, 16'd0, 1'b0);
        chk("rg.mem_addr", 32'(mem_addr), 32'(WA));
        chk("rg.mem_we", 32'(mem_we), 32'd1);
        HOLD = 1'b0; cpu_we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk_hs("rg.after", 1'b0, 1'b0, 16'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
